// File: rtl/l2_message_responder.sv
// L2-side endpoint of the L1->L2 message interface: FIFO, latency FSM, one response per message.
// Optional per-command completion counters are built when L2RESP_STATS_EN is defined.
module l2_message_responder #(
    parameter int FIFO_DEPTH = 4,
    parameter int READ_LAT   = 4,
    parameter int WRITE_LAT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_valid,
    input  logic [61:0] L2message,
    output logic        msg_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [1:0]  resp_cmd,
    output logic [59:0] resp_addr,
    output logic [1:0]  resp_result,
    output logic        processing,
    output logic [31:0] rd_count,
    output logic [31:0] rdown_count,
    output logic [31:0] wr_count,
    output logic [31:0] rtn_count
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    logic [LAT_W-1:0]   lat_cnt;
    logic [61:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [61:0]        head;
    logic               full;
    logic               push;
    logic               pop;
    logic               resp_done;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign full       = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign msg_ready  = !full;
    assign push       = msg_valid && msg_ready;
    assign pop        = (state == IDLE) && (fifo_cnt != '0);
    assign head       = mem[rd_ptr];
    assign processing = (state != IDLE) || (fifo_cnt != '0);
    assign resp_done  = (state == RESP) && resp_valid && resp_ready;

    // Message storage is data only; occupancy is tracked by pointers and count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= L2message;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            resp_valid  <= 1'b0;
            resp_cmd    <= 2'd0;
            resp_addr   <= 60'd0;
            resp_result <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_cnt != '0) begin
                        resp_cmd    <= head[1:0];
                        resp_addr   <= head[61:2];
                        resp_result <= head[1] ? 2'd1 : 2'd0;
                        lat_cnt     <= head[1] ? LAT_W'(READ_LAT) : LAT_W'(WRITE_LAT);
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    if (lat_cnt == LAT_W'(1)) begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef L2RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count    <= 32'd0;
            rdown_count <= 32'd0;
            wr_count    <= 32'd0;
            rtn_count   <= 32'd0;
        end else if (resp_done) begin
            case (resp_cmd)
                2'd0:    rtn_count   <= sat_inc(rtn_count);
                2'd1:    wr_count    <= sat_inc(wr_count);
                2'd2:    rd_count    <= sat_inc(rd_count);
                default: rdown_count <= sat_inc(rdown_count);
            endcase
        end
    end
`else
    assign rd_count    = 32'd0;
    assign rdown_count = 32'd0;
    assign wr_count    = 32'd0;
    assign rtn_count   = 32'd0;

    logic unused_stats;
    assign unused_stats = resp_done ^ (|sat_inc(32'd0));
`endif

endmodule

// File: tb/tb_l2_message_responder.sv
// Randomized self-checking bench for l2_message_responder against a queue-based timing model.
module tb_l2_message_responder;

    localparam int DEPTH = 4;
    localparam int RL    = 4;
    localparam int WL    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_valid;
    logic [61:0] L2message;
    logic        msg_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_cmd;
    logic [59:0] resp_addr;
    logic [1:0]  resp_result;
    logic        processing;
    logic [31:0] rd_count, rdown_count, wr_count, rtn_count;

    l2_message_responder #(.FIFO_DEPTH(DEPTH), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
        .clk(clk), .rst(rst), .msg_valid(msg_valid), .L2message(L2message),
        .msg_ready(msg_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_cmd(resp_cmd), .resp_addr(resp_addr), .resp_result(resp_result),
        .processing(processing), .rd_count(rd_count), .rdown_count(rdown_count),
        .wr_count(wr_count), .rtn_count(rtn_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: pending queue, one job in service that responds LAT edges after it starts.
    logic [61:0] mq[$];
    bit          m_busy = 1'b0;
    bit          m_valid = 1'b0;
    logic [61:0] m_job = '0;
    longint      m_due = 0;
    longint      cyc = 0;
    longint unsigned m_cnt[4] = '{0, 0, 0, 0};

    always @(posedge clk) begin
        bit acc;
        bit b0;
        bit v0;
        cyc++;
        if (rst) begin
            mq.delete();
            m_busy  = 1'b0;
            m_valid = 1'b0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            acc = msg_valid && (mq.size() < DEPTH);
            b0  = m_busy;
            v0  = m_valid;
            if (!b0 && mq.size() != 0) begin
                m_job  = mq.pop_front();
                m_busy = 1'b1;
                m_due  = cyc + (m_job[1] ? RL : WL);
            end else if (b0 && !v0 && cyc == m_due) begin
                m_valid = 1'b1;
            end else if (v0 && resp_ready) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
                if (m_cnt[m_job[1:0]] != 64'hFFFF_FFFF) m_cnt[m_job[1:0]]++;
            end
            if (acc) mq.push_back(L2message);
        end
    end

    function automatic logic [31:0] exp_cnt(input int c);
`ifdef L2RESP_STATS_EN
        return 32'(m_cnt[c]);
`else
        return 32'd0;
`endif
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("msg_ready", 64'(msg_ready), 64'(mq.size() < DEPTH));
            chk("resp_valid", 64'(resp_valid), 64'(m_valid));
            chk("processing", 64'(processing), 64'(m_busy || mq.size() != 0));
            if (m_valid) begin
                chk("resp_cmd", 64'(resp_cmd), 64'(m_job[1:0]));
                chk("resp_addr", 64'(resp_addr), 64'(m_job[61:2]));
                chk("resp_result", 64'(resp_result), m_job[1] ? 64'd1 : 64'd0);
            end
            chk("rtn_count", 64'(rtn_count), 64'(exp_cnt(0)));
            chk("wr_count", 64'(wr_count), 64'(exp_cnt(1)));
            chk("rd_count", 64'(rd_count), 64'(exp_cnt(2)));
            chk("rdown_count", 64'(rdown_count), 64'(exp_cnt(3)));
        end
    end

    task automatic send_one(input logic [1:0] cmd, input logic [59:0] addr);
        msg_valid = 1'b1;
        L2message = {addr, cmd};
        @(negedge clk);
        msg_valid = 1'b0;
    endtask

    task automatic wait_resp(output int k);
        k = 0;
        while (!resp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic drain();
        int k;
        resp_ready = 1'b1;
        msg_valid  = 1'b0;
        k = 0;
        while (processing && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", 64'(k < 200), 64'd1);
        @(negedge clk);
    endtask

    logic [59:0] exp_addr[5];
    logic [59:0] held_addr;
    logic [1:0]  held_cmd;
    int          k;
    int          got;

    initial begin
        rst        = 1'b1;
        msg_valid  = 1'b0;
        resp_ready = 1'b0;
        L2message  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_msg_ready", 64'(msg_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_processing", 64'(processing), 64'd0);
        chk("rst_resp_cmd", 64'(resp_cmd), 64'd0);
        chk("rst_resp_addr", 64'(resp_addr), 64'd0);
        chk("rst_resp_result", 64'(resp_result), 64'd0);
        chk("rst_counts", 64'(rd_count | rdown_count | wr_count | rtn_count), 64'd0);
        chk_en = 1'b1;

        // Single read: response visible after edge A+5.
        resp_ready = 1'b1;
        send_one(2'd2, 60'hABC);
        wait_resp(k);
        chk("read_latency", 64'(k), 64'd5);
        chk("read_result", 64'(resp_result), 64'd1);
        chk("read_addr", 64'(resp_addr), 64'hABC);
        repeat (2) @(negedge clk);
`ifdef L2RESP_STATS_EN
        chk("read_rd_count", 64'(rd_count), 64'd1);
`endif

        // Write latency: response after edge A+3.
        send_one(2'd1, 60'h123);
        wait_resp(k);
        chk("write_latency", 64'(k), 64'd3);
        chk("write_result", 64'(resp_result), 64'd0);
        repeat (2) @(negedge clk);
`ifdef L2RESP_STATS_EN
        chk("write_wr_count", 64'(wr_count), 64'd1);
`endif

        // Backpressure: 5 accepted, 6th refused, stalled response holds.
        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_addr[i] = 60'h100 + 60'(i);
            msg_valid   = 1'b1;
            L2message   = {exp_addr[i], 2'(i)};
            @(negedge clk);
        end
        chk("full_msg_ready", 64'(msg_ready), 64'd0);
        L2message = {60'hDEAD, 2'd3};
        repeat (3) @(negedge clk);
        msg_valid = 1'b0;
        wait_resp(k);
        held_addr = resp_addr;
        held_cmd  = resp_cmd;
        repeat (10) @(negedge clk);
        chk("stall_valid", 64'(resp_valid), 64'd1);
        chk("stall_addr", 64'(resp_addr), 64'(held_addr));
        chk("stall_cmd", 64'(resp_cmd), 64'(held_cmd));
        resp_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 200 && got < 5; i++) begin
            if (resp_valid) begin
                chk("order_addr", 64'(resp_addr), 64'(exp_addr[got]));
                got++;
            end
            @(negedge clk);
        end
        chk("order_count", 64'(got), 64'd5);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            msg_valid  = ($urandom_range(0, 99) < 45);
            L2message  = {32'($urandom), 28'($urandom), 2'($urandom_range(0, 3))};
            resp_ready = ($urandom_range(0, 99) < 65);
            @(negedge clk);
        end
        drain();

        // Reset while a read is waiting drops it entirely.
        send_one(2'd3, 60'h55);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) got++;
            @(negedge clk);
        end
        chk("rstwait_no_resp", 64'(got), 64'd0);
        chk("rstwait_processing", 64'(processing), 64'd0);
        chk("rstwait_counts", 64'(rd_count | rdown_count | wr_count | rtn_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
